banked_sram_read_ctrl: RTL and testbench
========================================

Name: banked_sram_read_ctrl

Overview:
Parametrised read controller for a multi-bank asynchronous SRAM array. It accepts read addresses over a valid/ready handshake and decodes the upper address bits to one of NUM_BANKS banks. It drives that bank's chip-enable and output-enable for a programmable number of access cycles, then returns the captured word over a valid/ready data handshake. It sits between the memory-request fabric and the off-core SRAM banks. It supports back-to-back reads with no idle bubble.

Parameters:
ADDR_WIDTH, 12, byte-agnostic word address width, including bank-select bits.
DATA_WIDTH, 32, SRAM data width.
NUM_BANKS, 4, number of SRAM banks; must be a power of 2, at least 2.
ACCESS_CYCLES, 6, cycles CE/OE are held low before data is sampled; must be at least 1.
Derived: BANK_BITS = log2(NUM_BANKS); ROW_WIDTH = ADDR_WIDTH - BANK_BITS.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
addr_valid_i  in  1  read request valid.
addr_ready_o  out  1  controller can accept a request this cycle.
addr_i  in  ADDR_WIDTH  read address; [ADDR_WIDTH-1 -: BANK_BITS] is the bank, [ROW_WIDTH-1:0] is the row.
data_valid_o  out  1  data_o holds a returned word.
data_ready_i  in  1  consumer accepts data_o.
data_o  out  DATA_WIDTH  returned read data, registered.
sram_ce_n  out  NUM_BANKS  per-bank chip enable, active low.
sram_oe_n  out  NUM_BANKS  per-bank output enable, active low.
sram_addr  out  ROW_WIDTH  row address, shared by all banks.
sram_data  in  DATA_WIDTH  shared SRAM read bus; only the enabled bank drives it.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE; counter = 0; latched row and bank = 0.
  - data_o = 0; data_valid_o = 0.
  - sram_ce_n and sram_oe_n all 1s; sram_addr = 0.
  - addr_ready_o = 1 in the cycle after reset.
  - Reset aborts any access in flight, including in ACCESS or DATA; the word in flight is lost.
- States: IDLE, ACCESS, DATA.
- addr_ready_o is combinational: (state == IDLE) OR (state == DATA AND data_ready_i). A ready-to-ready path exists and is permitted.
- Request accept = addr_valid_i AND addr_ready_o at a clk edge. On accept:
  - Latch row and bank from addr_i.
  - counter = 0; state goes to ACCESS.
- ACCESS:
  - sram_ce_n[bank] = 0 and sram_oe_n[bank] = 0; all other bits are 1.
  - sram_addr = latched row.
  - counter increments every cycle.
  - At the edge where counter == ACCESS_CYCLES-1: data_o <= sram_data; data_valid_o <= 1; state goes to DATA.
  - addr_valid_i is ignored; addr_ready_o = 0.
- DATA:
  - CE/OE are all 1s; data_valid_o = 1.
  - data_o holds stable until a data handshake occurs.
  - data_ready_i = 0: stay in DATA.
  - data_ready_i = 1 and addr_valid_i = 1: the data handshake and the new accept happen on the same edge. data_valid_o goes to 0, state goes to ACCESS with the new bank/row. This is back-to-back operation.
  - data_ready_i = 1 and addr_valid_i = 0: data_valid_o goes to 0, state goes to IDLE.
- Latency:
  - Accept edge to the first ACCESS cycle: 1 cycle.
  - Accept edge to data_valid_o high: ACCESS_CYCLES + 1 cycles. The DATA state takes at least one cycle.
  - Sustained back-to-back throughput: one word per ACCESS_CYCLES + 1 cycles.
- Glitch-free outputs: CE/OE/addr are decoded only from registered state and latched bank/row, never from addr_i directly.
- ACCESS_CYCLES = 1: ACCESS lasts exactly one cycle.
- Counter width is log2(ACCESS_CYCLES) + 1 bits. The counter never wraps because it is cleared on every accept.
- Never more than one bank has CE low in any cycle.

Test Plan:
- Single read: default parameters; reset, then one request addr_i=0x005 with data_ready_i=1 → sram_ce_n/oe_n = 4'b1110 for exactly 6 cycles with sram_addr=0x005; data_valid_o rises 7 cycles after the accept edge; data_o = sram_data value from the 6th cycle; state returns to IDLE.
- Bank decode: ACCESS_CYCLES=4; request addr_i=0xC05 → sram_ce_n = 4'b0111 for 4 cycles, sram_addr=0x005; requests 0x405 and 0x805 → ce_n = 1101 and 1011 respectively.
- Back-to-back: addr_valid_i held high with 3 addresses and data_ready_i=1 → 3 words returned on cycles 7, 14, 21 after the first accept; the IDLE state is never entered.
- Back-pressure: data_ready_i=0 for 5 cycles after data_valid_o rises → data_o stable and addr_ready_o=0 for all 5 cycles; the word is consumed on the cycle data_ready_i=1.
- Ignored request: addr_valid_i toggles during ACCESS → no change to sram_addr or ce_n; addr_ready_o=0 throughout.
- Reset mid-op: rst asserted on the 3rd ACCESS cycle → on the next cycle ce_n/oe_n = 4'b1111, data_valid_o=0, addr_ready_o=1; a following request completes normally.

Source files
------------

// File: rtl/banked_sram_read_ctrl.sv
// Read controller for a banked asynchronous SRAM: accepts word addresses, holds one bank's
// CE/OE low for ACCESS_CYCLES cycles, then returns the sampled word over a valid/ready port.
module banked_sram_read_ctrl #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_BANKS     = 4,
  parameter int ACCESS_CYCLES = 6
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        addr_valid_i,
  output logic                                        addr_ready_o,
  input  logic [ADDR_WIDTH-1:0]                       addr_i,
  output logic                                        data_valid_o,
  input  logic                                        data_ready_i,
  output logic [DATA_WIDTH-1:0]                       data_o,
  output logic [NUM_BANKS-1:0]                        sram_ce_n,
  output logic [NUM_BANKS-1:0]                        sram_oe_n,
  output logic [ADDR_WIDTH-$clog2(NUM_BANKS)-1:0]     sram_addr,
  input  logic [DATA_WIDTH-1:0]                       sram_data
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROW_WIDTH = ADDR_WIDTH - BANK_BITS;
  localparam int CNT_WIDTH = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DATA   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [ROW_WIDTH-1:0]   r_row;
  logic [NUM_BANKS-1:0]   r_en_n;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_valid;
  logic                   w_addr_ready;
  logic                   w_accept;
  logic                   w_access_done;
  logic [BANK_BITS-1:0]   w_bank_sel;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_BITS-1:0] bank);
    logic [NUM_BANKS-1:0] oh;
    oh       = '0;
    oh[bank] = 1'b1;
    return oh;
  endfunction

  assign w_bank_sel = addr_i[ADDR_WIDTH-1 -: BANK_BITS];

  // Handshake qualifiers and next-state decode
  always_comb begin
    w_addr_ready  = (r_state == S_IDLE) || ((r_state == S_DATA) && data_ready_i);
    w_accept      = addr_valid_i && w_addr_ready;
    w_access_done = (r_state == S_ACCESS) && (r_cnt == LAST_CNT);
    w_state_next  = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_ACCESS;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (w_access_done) begin
          w_state_next = S_DATA;
        end else begin
          w_state_next = S_ACCESS;
        end
      end
      S_DATA: begin
        if (data_ready_i) begin
          if (addr_valid_i) begin
            w_state_next = S_ACCESS;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_DATA;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latched request, access counter, registered strobes and returned word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_row   <= '0;
      r_en_n  <= '1;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      // Strobes are registered from the accept so the SRAM pins never follow addr_i glitches.
      if (w_accept) begin
        r_cnt  <= '0;
        r_row  <= addr_i[ROW_WIDTH-1:0];
        r_en_n <= ~bank_onehot(w_bank_sel);
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
        if (w_access_done) begin
          r_en_n <= '1;
        end else begin
          r_en_n <= r_en_n;
        end
      end else begin
        r_cnt  <= r_cnt;
        r_en_n <= r_en_n;
      end

      if (w_access_done) begin
        r_data  <= sram_data;
        r_valid <= 1'b1;
      end else if ((r_state == S_DATA) && data_ready_i) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign addr_ready_o = w_addr_ready;
  assign data_valid_o = r_valid;
  assign data_o       = r_data;
  assign sram_ce_n    = r_en_n;
  assign sram_oe_n    = r_en_n;
  assign sram_addr    = r_row;

endmodule

// File: tb/tb_banked_sram_read_ctrl.sv
// Self-checking bench for banked_sram_read_ctrl: transaction-level model compared every cycle
// plus directed scenarios with literal expectations.
module tb_banked_sram_read_ctrl;

  localparam int ACC = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_valid_i = 1'b0;
  logic        addr_ready_o;
  logic [11:0] addr_i = 12'h000;
  logic        data_valid_o;
  logic        data_ready_i = 1'b1;
  logic [31:0] data_o;
  logic [3:0]  sram_ce_n;
  logic [3:0]  sram_oe_n;
  logic [9:0]  sram_addr;
  logic [31:0] sram_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  banked_sram_read_ctrl #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_BANKS(4), .ACCESS_CYCLES(ACC)
  ) dut (
    .clk(clk), .rst(rst),
    .addr_valid_i(addr_valid_i), .addr_ready_o(addr_ready_o), .addr_i(addr_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_addr(sram_addr),
    .sram_data(sram_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM word content encodes the cycle, bank and row so capture timing is observable.
  function automatic logic [31:0] pattern(input int c, input logic [1:0] b, input logic [9:0] r);
    logic [31:0] cc;
    cc = c;
    return {2'b10, cc[15:0], 2'b00, b, r};
  endfunction

  always_comb begin
    sram_data = 32'h0BAD_0000;
    for (int i = 0; i < 4; i++) begin
      if (!sram_ce_n[i] && !sram_oe_n[i]) sram_data = pattern(cyc, 2'(i), sram_addr);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: remaining access cycles, pending word, latched request.
  int          m_left = 0;
  bit          m_have = 1'b0;
  logic [31:0] m_word = 32'h0;
  logic [1:0]  m_bank = 2'd0;
  logic [9:0]  m_row  = 10'd0;
  bit          mon_en = 1'b0;

  initial begin
    logic [3:0] exp_ce;
    bit         exp_ready;
    bit         acc;
    forever begin
      @(negedge clk);
      exp_ce    = (m_left > 0) ? ~(4'b0001 << m_bank) : 4'b1111;
      exp_ready = (m_left == 0 && !m_have) || (m_have && data_ready_i);
      if (mon_en) begin
        check("mon_addr_ready", addr_ready_o, exp_ready);
        check("mon_data_valid", data_valid_o, m_have);
        if (m_have) check("mon_data", data_o, m_word);
        check("mon_ce_n", sram_ce_n, exp_ce);
        check("mon_oe_n", sram_oe_n, exp_ce);
        if (m_left > 0) check("mon_sram_addr", sram_addr, m_row);
        check("mon_ce_onehot", ($countones(~sram_ce_n) <= 1), 1'b1);
      end
      if (rst) begin
        m_left = 0; m_have = 1'b0; m_word = 32'h0; m_bank = 2'd0; m_row = 10'd0;
        mon_en = 1'b1;
      end else begin
        acc = addr_valid_i && exp_ready;
        if (m_have && data_ready_i) m_have = 1'b0;
        if (m_left == 1) begin
          m_have = 1'b1;
          m_word = pattern(cyc, m_bank, m_row);
        end
        if (m_left > 0) m_left--;
        if (acc) begin
          m_left = ACC;
          m_bank = addr_i[11:10];
          m_row  = addr_i[9:0];
        end
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; addr_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_addr_ready", addr_ready_o, 1'b1);
    check("rst_data_valid", data_valid_o, 1'b0);
    check("rst_data", data_o, 32'h0);
    check("rst_ce_n", sram_ce_n, 4'b1111);
    check("rst_oe_n", sram_oe_n, 4'b1111);
    check("rst_sram_addr", sram_addr, 10'h000);
  endtask

  task automatic single_read(input logic [11:0] a, input logic [3:0] ce,
                             input logic [1:0] b, input logic [9:0] row);
    int n_ce, rise;
    logic [31:0] w, ew;
    n_ce = 0; rise = 0; w = 32'h0; ew = 32'h1;
    data_ready_i = 1'b1;
    @(posedge clk); #1;
    addr_i = a; addr_valid_i = 1'b1;
    @(negedge clk);
    check("sr_accept_ready", addr_ready_o, 1'b1);
    @(posedge clk); #1;
    addr_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (sram_ce_n == ce && sram_oe_n == ce && sram_addr == row) n_ce++;
      if (data_valid_o && rise == 0) begin
        rise = k;
        w    = data_o;
        ew   = pattern(cyc - 1, b, row);
      end
    end
    check("sr_ce_cycles", n_ce, 6);
    check("sr_valid_latency", rise, 7);
    check("sr_word", w, ew);
    check("sr_idle_ready", addr_ready_o, 1'b1);
  endtask

  initial begin
    logic [11:0] list [3];
    int accepted, nr, bad_ready, r, hold_bad, ign_bad;
    int rises [3];
    bit accept_now;
    logic [31:0] held;

    reset_dut();

    // Single read and bank decode (including the largest row)
    single_read(12'h005, 4'b1110, 2'd0, 10'h005);
    single_read(12'hC05, 4'b0111, 2'd3, 10'h005);
    single_read(12'h405, 4'b1101, 2'd1, 10'h005);
    single_read(12'h805, 4'b1011, 2'd2, 10'h005);
    single_read(12'h3FF, 4'b1110, 2'd0, 10'h3FF);

    // Back-to-back reads with addr_valid_i held high
    list[0] = 12'h123; list[1] = 12'hA10; list[2] = 12'h7FF;
    accepted = 0; nr = 0; bad_ready = 0;
    rises[0] = 0; rises[1] = 0; rises[2] = 0;
    data_ready_i = 1'b1;
    @(posedge clk); #1;
    addr_i = list[0]; addr_valid_i = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 21 && addr_ready_o != data_valid_o) bad_ready++;
      if (data_valid_o && nr < 3) begin
        rises[nr] = k;
        nr++;
      end
      accept_now = addr_valid_i && addr_ready_o;
      @(posedge clk); #1;
      if (accept_now) begin
        accepted++;
        if (accepted < 3) addr_i = list[accepted];
        else addr_valid_i = 1'b0;
      end
    end
    check("b2b_accepts", accepted, 3);
    check("b2b_word0_cycle", rises[0], 7);
    check("b2b_word1_cycle", rises[1], 14);
    check("b2b_word2_cycle", rises[2], 21);
    check("b2b_no_idle", bad_ready, 0);

    // Back-pressure: consumer stalls for 5 cycles
    data_ready_i = 1'b0;
    addr_i = 12'hC05; addr_valid_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    addr_valid_i = 1'b0;
    r = -1;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (data_valid_o) begin
        r = k;
        break;
      end
    end
    check("bp_rise", r, 6);
    held = data_o;
    hold_bad = 0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      if (data_o != held || addr_ready_o || !data_valid_o) hold_bad++;
    end
    check("bp_hold", hold_bad, 0);
    @(posedge clk); #1;
    data_ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_valid", data_valid_o, 1'b1);
    check("bp_release_ready", addr_ready_o, 1'b1);
    check("bp_release_data", data_o, held);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_consumed", data_valid_o, 1'b0);

    // Requests presented during ACCESS are ignored
    @(posedge clk); #1;
    addr_i = 12'h405; addr_valid_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    addr_valid_i = 1'b0;
    addr_i = 12'hC3F;
    ign_bad = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (sram_ce_n != 4'b1101 || sram_addr != 10'h005 || addr_ready_o) ign_bad++;
      @(posedge clk); #1;
      addr_valid_i = (k % 2 == 1);
    end
    addr_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("ign_access", ign_bad, 0);

    // Reset on the third ACCESS cycle
    @(posedge clk); #1;
    addr_i = 12'h805; addr_valid_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    addr_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_ce_before", sram_ce_n, 4'b1011);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_ce_n", sram_ce_n, 4'b1111);
    check("mid_oe_n", sram_oe_n, 4'b1111);
    check("mid_valid", data_valid_o, 1'b0);
    check("mid_ready", addr_ready_o, 1'b1);
    single_read(12'h105, 4'b1110, 2'd0, 10'h105);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
